// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type plus the instruction-cache address split, frame and FSM state.
// Used by icache and icache_frames (optional ICACHE_STATS_EN counters live in icache).
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Default cache geometry (16 frames, one word per frame).
  localparam int unsigned ICACHE_DEF_IDX_W = 4;
  localparam int unsigned ICACHE_DEF_TAG_W = 32 - ICACHE_DEF_IDX_W - 2;

  // Frame tags are stored at the widest possible size (one-frame cache) and
  // zero-extended, so the frame type stays independent of NSETS.
  localparam int unsigned ITAG_MAX_W = 30;

  typedef struct packed {
    logic [ICACHE_DEF_TAG_W-1:0] tag;
    logic [ICACHE_DEF_IDX_W-1:0] idx;
    logic [1:0]                  bytoff;
  } icachef_t;

  typedef struct packed {
    logic                  valid;
    logic [ITAG_MAX_W-1:0] tag;
    word_t                 data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } ISTATE;

endpackage

// File: rtl/icache_frames.sv
// Frame storage for icache: combinational indexed read, one write port, and a
// whole-array valid-bit clear on flush.
module icache_frames
  import cpu_types_pkg::*;
#(
  parameter  int unsigned NSETS = 16,
  localparam int unsigned IDX_W = $clog2(NSETS)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output icache_frame_t     rd_frame_o,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  icache_frame_t     wr_frame_i,
  input  logic              flush_i
);

  icache_frame_t frames_q [NSETS];

  // A write coinciding with a flush carries valid=0 from the caller, so the
  // later write assignment cannot resurrect the frame.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < NSETS; i++) begin
        frames_q[i] <= '0;
      end
    end else begin
      if (flush_i) begin
        for (int unsigned i = 0; i < NSETS; i++) begin
          frames_q[i].valid <= 1'b0;
        end
      end
      if (we_i) begin
        frames_q[wr_idx_i] <= wr_frame_i;
      end
    end
  end

  assign rd_frame_o = frames_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-block instruction cache: 0-cycle hits, single-word
// miss fill from the memory controller. `define ICACHE_STATS_EN adds hit/miss counters.
module icache
  import cpu_types_pkg::*;
#(
  parameter int unsigned NSETS = 16
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  input  logic  flush,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload
`ifdef ICACHE_STATS_EN
  ,
  output word_t hit_count,
  output word_t miss_count
`endif
);

  localparam int unsigned IDX_W = $clog2(NSETS);

  ISTATE         state_q;
  word_t         miss_addr_q;
  logic          iren_q;
  word_t         iaddr_q;

  logic [IDX_W-1:0]      req_idx;
  logic [ITAG_MAX_W-1:0] req_tag;
  icache_frame_t         rd_frame;
  logic                  lookup_hit;
  logic                  miss;
  logic                  fill;
  logic [IDX_W-1:0]      wr_idx;
  icache_frame_t         wr_frame;
  logic                  unused_bytoff;

  assign req_idx = imemaddr[IDX_W+1:2];
  assign req_tag = ITAG_MAX_W'(imemaddr[31:IDX_W+2]);
  assign unused_bytoff = ^{imemaddr[1:0], miss_addr_q[1:0]};

  always_comb begin
    lookup_hit = imemREN && rd_frame.valid && (rd_frame.tag == req_tag);
    ihit       = (state_q == IDLE) && lookup_hit && !flush;
    imemload   = ihit ? rd_frame.data : '0;
    miss       = (state_q == IDLE) && imemREN && !ihit;
    fill       = (state_q == FETCH) && !iwait;
    wr_idx         = miss_addr_q[IDX_W+1:2];
    wr_frame.valid = !flush;
    wr_frame.tag   = ITAG_MAX_W'(miss_addr_q[31:IDX_W+2]);
    wr_frame.data  = iload;
  end

  icache_frames #(.NSETS(NSETS)) u_frames (
    .CLK        (CLK),
    .nRST       (nRST),
    .rd_idx_i   (req_idx),
    .rd_frame_o (rd_frame),
    .we_i       (fill),
    .wr_idx_i   (wr_idx),
    .wr_frame_i (wr_frame),
    .flush_i    (flush)
  );

  // iREN/iaddr are registered so an asynchronous reset drops the request at once.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      iren_q      <= 1'b0;
      iaddr_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss) begin
            state_q     <= FETCH;
            miss_addr_q <= {imemaddr[31:2], 2'b00};
            iren_q      <= 1'b1;
            iaddr_q     <= {imemaddr[31:2], 2'b00};
          end
        end
        FETCH: begin
          if (!iwait) begin
            state_q <= IDLE;
            iren_q  <= 1'b0;
            iaddr_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          iren_q  <= 1'b0;
          iaddr_q <= '0;
        end
      endcase
    end
  end

  assign iREN  = iren_q;
  assign iaddr = iaddr_q;

`ifdef ICACHE_STATS_EN
  word_t hit_count_q;
  word_t miss_count_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (ihit) hit_count_q  <= hit_count_q + 32'd1;
      if (miss) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

  a_iaddr_stable: assert property (@(posedge CLK) disable iff (!nRST)
    (iREN && $past(iREN)) |-> (iaddr == $past(iaddr)));
  a_no_hit_in_fetch: assert property (@(posedge CLK) disable iff (!nRST)
    iREN |-> !ihit);

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table, reset-mid-fetch sequence,
// and randomized traffic against an array-based reference model.
module tb_icache;
  import cpu_types_pkg::*;

  localparam int unsigned NSETS = 16;

  logic  CLK = 1'b0;
  logic  nRST = 1'b0;
  logic  imemREN = 1'b0;
  word_t imemaddr = '0;
  logic  ihit;
  word_t imemload;
  logic  flush = 1'b0;
  logic  iREN;
  word_t iaddr;
  logic  iwait = 1'b1;
  word_t iload = '0;
`ifdef ICACHE_STATS_EN
  word_t hit_count;
  word_t miss_count;
`endif

  icache #(.NSETS(NSETS)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .flush      (flush),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  task automatic check(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ren, input word_t addr, input logic fl,
                       input logic wt, input word_t ld);
    imemREN  = ren;
    imemaddr = addr;
    flush    = fl;
    iwait    = wt;
    iload    = ld;
  endtask

  task automatic check_outs(input string tag, input logic e_hit, input word_t e_load,
                            input logic e_iren, input word_t e_iaddr);
    check({tag, ".ihit"},     word_t'(ihit),  word_t'(e_hit));
    check({tag, ".imemload"}, imemload,       e_load);
    check({tag, ".iREN"},     word_t'(iREN),  word_t'(e_iren));
    check({tag, ".iaddr"},    iaddr,          e_iaddr);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b1, '0);
    @(negedge CLK);
    #1;
    check_outs("reset", 1'b0, '0, 1'b0, '0);
`ifdef ICACHE_STATS_EN
    check("reset.hit_count",  hit_count,  '0);
    check("reset.miss_count", miss_count, '0);
`endif
    nRST = 1'b1;
  endtask

  typedef struct {
    logic  ren;
    word_t addr;
    logic  fl;
    logic  wt;
    word_t ld;
    logic  e_hit;
    word_t e_load;
    logic  e_iren;
    word_t e_iaddr;
  } vec_t;

  vec_t vecs[$];

  // Reference model: per-set valid/tag/data arrays and an outstanding-miss record.
  bit          m_valid [NSETS];
  int unsigned m_tag   [NSETS];
  word_t       m_data  [NSETS];
  bit          m_busy;
  word_t       m_addr;
  int unsigned m_hits, m_misses;

  function automatic int unsigned set_of(input word_t a);
    return (a / 4) % NSETS;
  endfunction

  function automatic int unsigned tag_of(input word_t a);
    return a / (4 * NSETS);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NSETS; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_data[i]  = '0;
    end
    m_busy = 1'b0;
    m_addr = '0;
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic random_cycle(input int c);
    logic  ren, fl, wt, e_hit, e_iren;
    word_t addr, ld, e_load, e_iaddr;
    int unsigned s;
    @(negedge CLK);
    ren  = ($urandom_range(0, 3) != 0);
    addr = (word_t'($urandom_range(0, 3)) << 6) | (word_t'($urandom_range(0, 15)) << 2)
         | word_t'($urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) addr = $urandom;
    fl   = ($urandom_range(0, 24) == 0);
    wt   = ($urandom_range(0, 2) != 0);
    ld   = $urandom;
    drive(ren, addr, fl, wt, ld);
    #1;
    s = set_of(addr);
    if (!m_busy) begin
      e_hit   = ren && m_valid[s] && (m_tag[s] == tag_of(addr)) && !fl;
      e_load  = e_hit ? m_data[s] : '0;
      e_iren  = 1'b0;
      e_iaddr = '0;
    end else begin
      e_hit   = 1'b0;
      e_load  = '0;
      e_iren  = 1'b1;
      e_iaddr = m_addr;
    end
    check_outs($sformatf("rand%0d", c), e_hit, e_load, e_iren, e_iaddr);
`ifdef ICACHE_STATS_EN
    check($sformatf("rand%0d.hit_count", c),  hit_count,  word_t'(m_hits));
    check($sformatf("rand%0d.miss_count", c), miss_count, word_t'(m_misses));
`endif
    // state update for the coming edge
    if (m_busy) begin
      if (!wt) begin
        m_valid[set_of(m_addr)] = 1'b1;
        m_tag[set_of(m_addr)]   = tag_of(m_addr);
        m_data[set_of(m_addr)]  = ld;
        m_busy = 1'b0;
      end
    end else if (ren && !e_hit) begin
      m_busy = 1'b1;
      m_addr = addr - (addr % 4);
      m_misses++;
    end
    if (fl) for (int i = 0; i < NSETS; i++) m_valid[i] = 1'b0;
    if (e_hit) m_hits++;
  endtask

  initial begin
    // ren, addr, flush, iwait, iload | hit, imemload, iREN, iaddr
    vecs.push_back('{1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0});   // cold miss
    vecs.push_back('{1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        1, 32'h40});
    vecs.push_back('{1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        1, 32'h40});
    vecs.push_back('{1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        1, 32'h40});
    vecs.push_back('{1, 32'h40,  0, 0, 32'hDEADBEEF, 0, 32'h0,        1, 32'h40});  // fill
    vecs.push_back('{1, 32'h40,  0, 1, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0});
    vecs.push_back('{1, 32'h43,  0, 1, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0});   // unaligned
    vecs.push_back('{0, 32'h43,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0});
    vecs.push_back('{1, 32'h440, 0, 1, 32'h0,        0, 32'h0,        0, 32'h0});   // conflict
    vecs.push_back('{1, 32'h440, 0, 0, 32'hCAFEF00D, 0, 32'h0,        1, 32'h440});
    vecs.push_back('{1, 32'h440, 0, 1, 32'h0,        1, 32'hCAFEF00D, 0, 32'h0});
    vecs.push_back('{1, 32'h40,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0});   // evicted
    vecs.push_back('{1, 32'h40,  0, 0, 32'hDEADBEEF, 0, 32'h0,        1, 32'h40});
    vecs.push_back('{1, 32'h40,  0, 1, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0});
    vecs.push_back('{1, 32'h80,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0});   // abandoned
    vecs.push_back('{1, 32'h84,  0, 1, 32'h0,        0, 32'h0,        1, 32'h80});
    vecs.push_back('{0, 32'h84,  0, 0, 32'h11112222, 0, 32'h0,        1, 32'h80});
    vecs.push_back('{1, 32'h80,  0, 1, 32'h0,        1, 32'h11112222, 0, 32'h0});
    vecs.push_back('{1, 32'h84,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0});
    vecs.push_back('{1, 32'h84,  0, 0, 32'h33334444, 0, 32'h0,        1, 32'h84});
    vecs.push_back('{1, 32'h84,  0, 1, 32'h0,        1, 32'h33334444, 0, 32'h0});
    vecs.push_back('{0, 32'h0,   1, 1, 32'h0,        0, 32'h0,        0, 32'h0});   // flush
    vecs.push_back('{1, 32'h80,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0});
    vecs.push_back('{1, 32'h80,  0, 1, 32'h0,        0, 32'h0,        1, 32'h80});
    vecs.push_back('{1, 32'h80,  1, 0, 32'h55556666, 0, 32'h0,        1, 32'h80});  // flush on fill
    vecs.push_back('{1, 32'h80,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0});
    vecs.push_back('{1, 32'h80,  0, 0, 32'h77778888, 0, 32'h0,        1, 32'h80});
    vecs.push_back('{1, 32'h80,  0, 1, 32'h0,        1, 32'h77778888, 0, 32'h0});
    vecs.push_back('{1, 32'h84,  0, 1, 32'h0,        0, 32'h0,        0, 32'h0});
    vecs.push_back('{0, 32'h0,   0, 0, 32'h0,        0, 32'h0,        1, 32'h84});
    vecs.push_back('{0, 32'h0,   0, 1, 32'h0,        0, 32'h0,        0, 32'h0});

    do_reset();
    foreach (vecs[i]) begin
      @(negedge CLK);
      drive(vecs[i].ren, vecs[i].addr, vecs[i].fl, vecs[i].wt, vecs[i].ld);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].e_hit, vecs[i].e_load,
                 vecs[i].e_iren, vecs[i].e_iaddr);
`ifdef ICACHE_STATS_EN
      if (i == 14) begin
        check("vec14.miss_count", miss_count, 32'd3);
        check("vec14.hit_count",  hit_count,  32'd4);
      end
`endif
    end
`ifdef ICACHE_STATS_EN
    @(negedge CLK);
    check("table.miss_count", miss_count, 32'd8);
    check("table.hit_count",  hit_count,  32'd7);
`endif

    // Reset in the middle of a fetch: request must vanish immediately.
    @(negedge CLK);
    drive(1'b1, 32'h80, 1'b0, 1'b1, '0);
    #1;
    check_outs("rst.prehit", 1'b1, 32'h77778888, 1'b0, '0);
    @(negedge CLK);
    drive(1'b1, 32'hC0, 1'b0, 1'b1, '0);
    #1;
    check_outs("rst.miss", 1'b0, '0, 1'b0, '0);
    @(negedge CLK);
    #1;
    check_outs("rst.fetch", 1'b0, '0, 1'b1, 32'hC0);
    nRST = 1'b0;
    #1;
    check_outs("rst.async", 1'b0, '0, 1'b0, '0);
    @(negedge CLK);
    nRST = 1'b1;
    drive(1'b1, 32'h80, 1'b0, 1'b1, '0);
    #1;
    check_outs("rst.after", 1'b0, '0, 1'b0, '0);
    @(negedge CLK);
    drive(1'b1, 32'h80, 1'b0, 0, 32'h9999AAAA);
    #1;
    check_outs("rst.refetch", 1'b0, '0, 1'b1, 32'h80);
    @(negedge CLK);
    drive(1'b1, 32'h80, 1'b0, 1'b1, '0);
    #1;
    check_outs("rst.refill", 1'b1, 32'h9999AAAA, 1'b0, '0);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) random_cycle(c);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
